// File: rtl/cdc_sync_filter.sv
// ---------------------------------------------------------------------------
// cdc_sync_filter
//   Receive-side synchroniser for WIDTH independent asynchronous single-bit
//   signals entering the clk domain. Each channel runs through a STAGES-deep
//   flop chain. An optional glitch filter then requires FILT_CYCLES consecutive
//   differing cycles before the output level follows. Each channel also has
//   one-cycle rise and fall pulse outputs.
//
//   Optional feature macro: SYNC_GLITCH_FILTER_EN
//     defined   : per-channel filter counters plus a saturating glitch counter.
//     undefined : o_data follows the last sync stage every cycle.
//                 o_glitch_cnt is tied to 0, and i_cnt_clr and FILT_CYCLES
//                 are unused.
//
// Ports
//   clk          in   1      receiving clock
//   rst          in   1      synchronous reset, active-high
//   i_data       in   WIDTH  asynchronous inputs, no timing relation to clk
//   i_cnt_clr    in   1      synchronous clear of o_glitch_cnt
//   o_data       out  WIDTH  synchronised (filtered) level per channel
//   o_rise       out  WIDTH  1-cycle pulse on o_data[n] 0->1
//   o_fall       out  WIDTH  1-cycle pulse on o_data[n] 1->0
//   o_glitch_cnt out  CNT_W  saturating count of cycles with a rejected glitch
// ---------------------------------------------------------------------------
module cdc_sync_filter #(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_cnt_clr,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [CNT_W-1:0] o_glitch_cnt
);

  // Bit 0 of each chain is the only flop that samples i_data. The path into
  // it is a false path. No logic sits between the chain flops.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q [WIDTH];

  logic [WIDTH-1:0] s;       // last synchroniser stage per channel
  logic [WIDTH-1:0] commit;  // o_data[n] takes s[n] at this edge

  // NOTE: the chain is an array of flops, but it is still reset explicitly so
  // that in-flight values are discarded and no stale edge emerges after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      for (int n = 0; n < WIDTH; n++) sync_q[n] <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) sync_q[n] <= {sync_q[n][STAGES-2:0], i_data[n]};
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    s = '0;
    for (int n = 0; n < WIDTH; n++) s[n] = sync_q[n][STAGES-1];
  end

`ifdef SYNC_GLITCH_FILTER_EN
  localparam int               FC_W    = $clog2(FILT_CYCLES) + 1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_CYCLES - 1);

  logic [FC_W-1:0]  fc_q [WIDTH];
  logic [WIDTH-1:0] abort;    // a run in progress fell back to o_data

  always_comb begin
    commit = '0;
    abort  = '0;
    for (int n = 0; n < WIDTH; n++) begin
      if (s[n] != o_data[n]) commit[n] = (fc_q[n] == FC_LAST);
      else                   abort[n]  = (fc_q[n] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < WIDTH; n++) fc_q[n] <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        if (s[n] == o_data[n] || fc_q[n] == FC_LAST) fc_q[n] <= '0;
        else                                         fc_q[n] <= fc_q[n] + 1'b1;
      end
    end
  end

  // One increment per cycle, however many channels abort in that cycle.
  // The clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || i_cnt_clr)                   o_glitch_cnt <= '0;
    else if (|abort && o_glitch_cnt != '1)  o_glitch_cnt <= o_glitch_cnt + 1'b1;
  end
`else
  // Without the filter, o_data tracks s with one cycle of delay.
  assign commit       = s ^ o_data;
  assign o_glitch_cnt = '0;

  logic unused_cfg;
  assign unused_cfg = ^{i_cnt_clr, FILT_CYCLES[0]};
`endif

  // The pulses come from the same commit as the level change, so rise and
  // fall on one channel are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
      o_rise <= '0;
      o_fall <= '0;
    end else begin
      o_data <= o_data ^ commit;
      o_rise <= commit & s;
      o_fall <= commit & ~s;
    end
  end

endmodule
